// File: rtl/lc3b_types.sv
// Shared types for the LC-3b fetch path.
// Redirect selector encoding and trap shift.
package lc3b_types;

  typedef enum logic [1:0] {
    PCR_REL  = 2'd0,
    PCR_ABS  = 2'd1,
    PCR_TRAP = 2'd2
  } pc_redirect_sel_t;

  localparam int TRAP_SHIFT = 1;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation.
// Pure combinational adder and selector.
module pc_target_calc #(
  parameter int WIDTH    = 16,
  parameter int OFFSET_W = 11
) (
  input  logic [1:0]          sel,
  input  logic [WIDTH-1:0]    base,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [7:0]          trapvect,
  output logic [WIDTH-1:0]    target
);
  import lc3b_types::*;

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] trap_ext;

  assign off_ext  = WIDTH'($signed(offset)) << 1;
  assign trap_ext = WIDTH'(trapvect) << TRAP_SHIFT;

  // Reserved encoding falls through to absolute.
  always_comb begin
    target = base;
    unique case (1'b1)
      (sel == PCR_REL):  target = base + off_ext;
      (sel == PCR_TRAP): target = trap_ext;
      default:           target = base;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch.
// Redirects arriving mid-request are deferred.
module pc_fetch_unit #(
  parameter int               WIDTH     = 16,
  parameter int               INC       = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               OFFSET_W  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                stall,
  input  logic                mem_resp,
  output logic                mem_read,
  output logic [WIDTH-1:0]    mem_address,
  output logic                fetch_valid,
  output logic [WIDTH-1:0]    fetch_pc,
  output logic [WIDTH-1:0]    pc_plus_inc,
  input  logic                redirect_valid,
  input  logic [1:0]          redirect_sel,
  input  logic [WIDTH-1:0]    redirect_base,
  input  logic [OFFSET_W-1:0] redirect_offset,
  input  logic [7:0]          trapvect
);
  import lc3b_types::*;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] pend_target, pend_target_n;
  logic             pend_valid, pend_valid_n;
  logic [WIDTH-1:0] target;
  logic             squash;
  state_t           after;

  pc_target_calc #(
    .WIDTH    (WIDTH),
    .OFFSET_W (OFFSET_W)
  ) u_calc (
    .sel      (redirect_sel),
    .base     (redirect_base),
    .offset   (redirect_offset),
    .trapvect (trapvect),
    .target   (target)
  );

  assign squash      = pend_valid | redirect_valid;
  assign after       = en ? FETCH : IDLE;
  assign mem_read    = (state == FETCH);
  assign mem_address = pc;
  assign fetch_pc    = pc;
  assign pc_plus_inc = pc + INC_W;

  // Next-state, PC and deferred-redirect selection.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_target_n = pend_target;
    pend_valid_n  = pend_valid;
    fetch_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) pc_n = target;
        if (en) state_n = FETCH;
      end
      FETCH: begin
        if (!mem_resp) begin
          if (redirect_valid) begin
            pend_target_n = target;
            pend_valid_n  = 1'b1;
          end
        end else if (squash) begin
          pc_n         = redirect_valid ? target : pend_target;
          pend_valid_n = 1'b0;
          state_n      = after;
        end else begin
          fetch_valid = 1'b1;
          if (stall) begin
            state_n = HOLD;
          end else begin
            pc_n    = pc_plus_inc;
            state_n = after;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = target;
          state_n = after;
        end else begin
          fetch_valid = 1'b1;
          if (!stall) begin
            pc_n    = pc_plus_inc;
            state_n = after;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VEC;
      pend_target <= '0;
      pend_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_target <= pend_target_n;
      pend_valid  <= pend_valid_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit and pc_target_calc.
// Vector table plus scoreboarded fetch sequences.
module tb_pc_fetch_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        mem_resp = 1'b0;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic [15:0] pc_plus_inc;
  logic        rv = 1'b0;
  logic [1:0]  rsel = 2'd0;
  logic [15:0] rbase = '0;
  logic [10:0] roff = '0;
  logic [7:0]  tvec = '0;

  logic [1:0]  c_sel;
  logic [15:0] c_base;
  logic [10:0] c_off;
  logic [7:0]  c_tv;
  logic [15:0] c_tgt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] base;
    logic [10:0] off;
    logic [7:0]  tv;
    logic [15:0] exp;
  } tv_t;

  tv_t vec[8];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .stall           (stall),
    .mem_resp        (mem_resp),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .pc_plus_inc     (pc_plus_inc),
    .redirect_valid  (rv),
    .redirect_sel    (rsel),
    .redirect_base   (rbase),
    .redirect_offset (roff),
    .trapvect        (tvec)
  );

  pc_target_calc #(
    .WIDTH    (16),
    .OFFSET_W (11)
  ) u_calc (
    .sel      (c_sel),
    .base     (c_base),
    .offset   (c_off),
    .trapvect (c_tv),
    .target   (c_tgt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Settle, then score any accepted delivery.
  task automatic sample();
    #1;
    if (fetch_valid && !stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery",
            {16'h0, fetch_pc}, 32'hFFFF_FFFF);
      end else begin
        chk("deliver_pc", {16'h0, fetch_pc},
            {16'h0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic go_to(input logic [15:0] a);
    en = 1'b0;
    mem_resp = 1'b0;
    rv = 1'b1;
    rsel = PCR_ABS;
    rbase = a;
    sample(); nx();
    rv = 1'b0;
    sample();
    chk("goto_pc", {16'h0, fetch_pc}, {16'h0, a});
    nx();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{PCR_REL,  16'h3002, 11'h7FC, 8'h00, 16'h2FFA};
    vec[1] = '{PCR_REL,  16'hFFFE, 11'h002, 8'h00, 16'h0002};
    vec[2] = '{PCR_REL,  16'h0000, 11'h400, 8'h00, 16'hF800};
    vec[3] = '{PCR_REL,  16'h1234, 11'h3FF, 8'h00, 16'h1A32};
    vec[4] = '{PCR_ABS,  16'h1234, 11'h155, 8'h77, 16'h1234};
    vec[5] = '{2'd3,     16'hBEEF, 11'h001, 8'h11, 16'hBEEF};
    vec[6] = '{PCR_TRAP, 16'h5555, 11'h010, 8'h25, 16'h004A};
    vec[7] = '{PCR_TRAP, 16'h0000, 11'h000, 8'hFF, 16'h01FE};

    for (int i = 0; i < 8; i++) begin
      c_sel  = vec[i].sel;
      c_base = vec[i].base;
      c_off  = vec[i].off;
      c_tv   = vec[i].tv;
      #1;
      chk($sformatf("calc_vec%0d", i),
          {16'h0, c_tgt}, {16'h0, vec[i].exp});
    end

    nx();
    #1;
    chk("rst_mem_read", {31'h0, mem_read}, 0);
    chk("rst_valid", {31'h0, fetch_valid}, 0);
    chk("rst_pc", {16'h0, fetch_pc}, 0);
    chk("rst_inc", {16'h0, pc_plus_inc}, 2);
    nx();
    rst = 1'b0;

    // sequential fetch, zero-wait memory
    en = 1'b1;
    mem_resp = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    sample();
    chk("seq_idle_read", {31'h0, mem_read}, 0);
    nx();
    sample();
    chk("seq_addr0", {16'h0, mem_address}, 0);
    nx();
    sample();
    chk("seq_addr1", {16'h0, mem_address}, 2);
    nx();
    en = 1'b0;
    sample();
    chk("seq_addr2", {16'h0, mem_address}, 4);
    nx();
    mem_resp = 1'b0;
    sample();
    chk("seq_idle_pc", {16'h0, fetch_pc}, 6);
    nx();

    // REL redirect deferred mid-request
    go_to(16'h3000);
    en = 1'b1;
    sample(); nx();
    rv = 1'b1;
    rsel = PCR_REL;
    rbase = 16'h3002;
    roff = 11'h7FC;
    sample();
    chk("rel_read", {31'h0, mem_read}, 1);
    chk("rel_addr_c1", {16'h0, mem_address}, 16'h3000);
    nx();
    rv = 1'b0;
    sample();
    chk("rel_addr_c2", {16'h0, mem_address}, 16'h3000);
    nx();
    sample();
    chk("rel_addr_c3", {16'h0, mem_address}, 16'h3000);
    nx();
    mem_resp = 1'b1;
    sample();
    chk("rel_squash", {31'h0, fetch_valid}, 0);
    nx();
    en = 1'b0;
    exp_q.push_back(16'h2FFA);
    sample();
    chk("rel_next_addr", {16'h0, mem_address}, 16'h2FFA);
    nx();
    mem_resp = 1'b0;

    // TRAP coincident with the response
    go_to(16'h0100);
    en = 1'b1;
    sample(); nx();
    mem_resp = 1'b1;
    rv = 1'b1;
    rsel = PCR_TRAP;
    tvec = 8'h25;
    sample();
    chk("trap_squash", {31'h0, fetch_valid}, 0);
    nx();
    rv = 1'b0;
    en = 1'b0;
    exp_q.push_back(16'h004A);
    sample();
    chk("trap_addr", {16'h0, mem_address}, 16'h004A);
    nx();
    mem_resp = 1'b0;

    // stall hold, then release
    go_to(16'h0010);
    en = 1'b1;
    sample(); nx();
    mem_resp = 1'b1;
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) mem_resp = 1'b0;
      if (c == 3) begin
        stall = 1'b0;
        exp_q.push_back(16'h0010);
      end
      sample();
      chk($sformatf("hold_valid%0d", c),
          {31'h0, fetch_valid}, 1);
      chk($sformatf("hold_pc%0d", c),
          {16'h0, fetch_pc}, 16'h0010);
      if (c > 0)
        chk($sformatf("hold_read%0d", c),
            {31'h0, mem_read}, 0);
      nx();
    end
    en = 1'b0;
    mem_resp = 1'b1;
    exp_q.push_back(16'h0012);
    sample();
    chk("hold_next_addr", {16'h0, mem_address}, 16'h0012);
    nx();
    mem_resp = 1'b0;

    // redirect flushes a held instruction
    go_to(16'h0020);
    en = 1'b1;
    sample(); nx();
    mem_resp = 1'b1;
    stall = 1'b1;
    sample(); nx();
    mem_resp = 1'b0;
    rv = 1'b1;
    rsel = PCR_ABS;
    rbase = 16'h0040;
    sample();
    chk("hold_flush", {31'h0, fetch_valid}, 0);
    nx();
    rv = 1'b0;
    stall = 1'b0;
    en = 1'b0;
    sample();
    chk("flush_addr", {16'h0, mem_address}, 16'h0040);
    chk("flush_read", {31'h0, mem_read}, 1);
    mem_resp = 1'b1;
    exp_q.push_back(16'h0040);
    sample();
    nx();
    mem_resp = 1'b0;

    // wrap-around on REL and on increment
    go_to(16'hFFFE);
    chk("wrap_inc", {16'h0, pc_plus_inc}, 0);
    rv = 1'b1;
    rsel = PCR_REL;
    rbase = 16'hFFFE;
    roff = 11'h002;
    sample(); nx();
    rv = 1'b0;
    sample();
    chk("wrap_rel", {16'h0, fetch_pc}, 16'h0002);
    nx();
    go_to(16'hFFFE);
    en = 1'b1;
    sample(); nx();
    mem_resp = 1'b1;
    exp_q.push_back(16'hFFFE);
    sample(); nx();
    en = 1'b0;
    exp_q.push_back(16'h0000);
    sample();
    chk("wrap_seq", {16'h0, mem_address}, 0);
    nx();
    mem_resp = 1'b0;

    // async reset mid-request
    go_to(16'h0200);
    en = 1'b1;
    sample(); nx();
    sample();
    chk("arst_pre_read", {31'h0, mem_read}, 1);
    rst = 1'b1;
    #1;
    chk("arst_read", {31'h0, mem_read}, 0);
    chk("arst_pc", {16'h0, fetch_pc}, 0);
    nx();
    rst = 1'b0;
    en = 1'b0;
    sample(); nx();

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch-request block, replacing the fixed two-input PC mux and register pair. It holds the PC and drives a single-outstanding read request to instruction memory, handshaking on mem_resp. It applies relative, absolute and trap-vector redirects, deferring any redirect that arrives mid-request. It delivers each fetched instruction's PC to decode, with stall backpressure.

Parameters:
WIDTH, 16, PC and address width in bits.
INC, 2, sequential PC increment in bytes.
RESET_VEC, 16'h0000, PC value loaded on reset; WIDTH bits wide.
OFFSET_W, 11, width of the signed redirect offset in words.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  fetch enable; when low, no new request is started.
stall  in  1  decode cannot accept an instruction this cycle.
mem_resp  in  1  instruction memory has completed the current read.
mem_read  out  1  read request; held high until mem_resp.
mem_address  out  WIDTH  fetch address; always equals pc.
fetch_valid  out  1  the instruction at fetch_pc is valid for decode.
fetch_pc  out  WIDTH  current PC.
pc_plus_inc  out  WIDTH  pc + INC, modulo 2^WIDTH; used as the link value.
redirect_valid  in  1  one-cycle redirect strobe.
redirect_sel  in  2  redirect mode, using the package enum: 0 REL, 1 ABS, 2 TRAP, 3 reserved (treated as ABS).
redirect_base  in  WIDTH  base address for REL; full target for ABS.
redirect_offset  in  OFFSET_W  signed word offset for REL.
trapvect  in  8  trap vector for TRAP.

Behaviour:
- Redirect target (combinational):
  - REL: base + (sext(offset) << 1).
  - ABS: base.
  - TRAP: zext(trapvect) << 1.
  - All results truncated to WIDTH; wrap-around is silent.
- State machine, in states IDLE, FETCH and HOLD:
  - Reset values: state IDLE, pc = RESET_VEC, pend_valid = 0, mem_read = 0, fetch_valid = 0. Reset is effective immediately, including mid-request.
  - mem_read = (state == FETCH).
  - fetch_valid = (FETCH & mem_resp & !squash) | (HOLD & !redirect_valid).
  - squash = pend_valid | redirect_valid.
- IDLE:
  - A redirect sets pc <= target.
  - If en is high, go to FETCH next cycle; the first request is issued 1 cycle after en rises.
- FETCH, no mem_resp:
  - pc and mem_address stay stable.
  - A redirect is stored in the pending register, pend_target <= target and pend_valid <= 1.
  - A later redirect overwrites the pending one; the newest redirect wins.
- FETCH with mem_resp and squash:
  - The instruction is dropped and fetch_valid stays 0.
  - pc <= redirect target if redirect_valid is high this cycle, otherwise pend_target.
  - pend_valid <= 0.
  - Next state is FETCH if en is high, else IDLE.
- FETCH with mem_resp, no squash:
  - fetch_valid = 1 in the same cycle.
  - If stall is high: go to HOLD, pc unchanged.
  - If stall is low: pc <= pc + INC, and go to FETCH if en is high, else IDLE.
- HOLD:
  - fetch_valid stays 1 and fetch_pc is stable.
  - When stall drops: pc <= pc + INC, then go to FETCH or IDLE according to en.
  - A redirect takes priority over stall: pc <= target, the held instruction is flushed, and the next state follows en.
- en low during FETCH: the outstanding request still completes.
- Throughput: with zero-wait memory (mem_resp in the first FETCH cycle), one instruction is delivered per cycle.

Decomposition:
- lc3b_types gains:
  - pc_redirect_sel_t enum {PCR_REL, PCR_ABS, PCR_TRAP}.
  - A localparam for the trap shift amount (1).
- The state enum stays local to the module.
- One sub-module: pc_target_calc, a purely combinational target adder and select parametrised by WIDTH and OFFSET_W. It is unit-tested alone.

Test Plan:
- Reset and sequential fetch: rst pulse, en = 1, mem_resp on every FETCH cycle (default parameters) -> mem_address sequence 0x0000, 0x0002, 0x0004, with fetch_valid high on each response.
- Mid-request REL redirect: pc = 0x3000, mem_resp delayed 3 cycles, REL base = 0x3002, offset = -4 in cycle 1 -> address holds 0x3000 until mem_resp; that response is squashed; next mem_address = 0x2FFA.
- TRAP redirect coincident with mem_resp: trapvect = 0x25 -> fetch_valid = 0 that cycle; next mem_address = 0x004A.
- Stall hold then release: response at pc = 0x0010 with stall high for 3 cycles -> fetch_valid and fetch_pc = 0x0010 held for 4 cycles, mem_read = 0; next address 0x0012.
- Wrap-around and async reset: pc = 0xFFFE, then a REL redirect with base = 0xFFFE, offset = +2 -> target 0x0002. A separate 0xFFFE sequential step gives 0x0000. rst asserted mid-FETCH -> mem_read drops without a clock edge and pc = RESET_VEC.
